// File: rtl/awgn_pkg.sv
// awgn_pkg: shared constants, types and helpers for the AWGN core.
//   SQRT_IN_W / SQRT_OUT_W : radicand / root widths of the shared sqrt unit
//   SQRT_LAT_DFLT          : default sqrt pipeline latency (clock edges)
//   tag_t                  : in-flight operand tag {valid, id}
//   isqrt()                : floor integer square root, bit-serial form
package awgn_pkg;

  localparam int SQRT_IN_W     = 31;
  localparam int SQRT_OUT_W    = 17;
  localparam int SQRT_LAT_DFLT = 5;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_IDW       = 3;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  // Classic restoring square root: one result bit per iteration,
  // starting from the highest even power of two in the radicand range.
  function automatic logic [SQRT_OUT_W-1:0] isqrt(input logic [SQRT_IN_W-1:0] x);
    logic [31:0] rem, root, bitv;
    rem  = {1'b0, x};
    root = '0;
    bitv = 32'h4000_0000;
    for (int i = 0; i < 16; i++) begin
      if (rem >= root + bitv) begin
        rem  = rem - (root + bitv);
        root = (root >> 1) + bitv;
      end else begin
        root = root >> 1;
      end
      bitv = bitv >> 2;
    end
    return root[SQRT_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/sqrt.sv
// sqrt: fixed-latency integer square root, out = floor(sqrt(in)).
//   clk : rising-edge clock
//   in  : SQRT_IN_W-bit radicand
//   out : SQRT_OUT_W-bit root, valid LAT edges after 'in'
// No reset: the owner masks stale contents with its own tags.
module sqrt
  import awgn_pkg::*;
#(
  parameter int LAT = SQRT_LAT_DFLT
) (
  input  logic                  clk,
  input  logic [SQRT_IN_W-1:0]  in,
  output logic [SQRT_OUT_W-1:0] out
);

  // Root is resolved in the first stage; the remaining stages only
  // carry it so the unit presents the fixed latency its users expect.
  logic [LAT-1:0][SQRT_OUT_W-1:0] pipe;

  always_ff @(posedge clk) begin
    pipe[0] <= isqrt(in);
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end

  assign out = pipe[LAT-1];

endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin sharing of one pipelined sqrt among N requesters.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_data   : operands, requester i at [31*i +: 31]
//   req_ready  : one-hot/zero grant, combinational from req_valid and last
//   res_valid  : one-hot/zero result strobe for the owning requester
//   res_data   : root from sqrt
//   res_id     : index of the requester owning res_data
//   idle       : no operand in the input register or sqrt pipeline
module sqrt_arbiter
  import awgn_pkg::*;
#(
  parameter int N        = 2,
  parameter int SQRT_LAT = SQRT_LAT_DFLT,
  parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  input  logic [SQRT_IN_W*N-1:0] req_data,
  output logic [N-1:0]           req_ready,
  output logic [N-1:0]           res_valid,
  output logic [SQRT_OUT_W-1:0]  res_data,
  output logic [IDW-1:0]         res_id,
  output logic                   idle
);

  logic [IDW-1:0]        last;
  logic                  acc;
  logic [IDW-1:0]        gnt_id;
  logic [N-1:0]          gnt;
  logic [SQRT_IN_W-1:0]  sq_in;
  logic [SQRT_OUT_W-1:0] sq_out;
  logic                  res_vld;

  // tag_pipe[0] travels with sq_in; tag_pipe[SQRT_LAT] lines up with sq_out.
  tag_t [SQRT_LAT:0] tag_pipe;

  // Returns {found, id}. Offsets are scanned from far to near so the
  // nearest valid requester after 'l' is the last (winning) assignment.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] v, input logic [IDW-1:0] l);
    logic [IDW:0] r;
    int idx;
    r = '0;
    for (int o = N; o >= 1; o--) begin
      idx = (int'(l) + o) % N;
      if (v[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    {acc, gnt_id} = rst ? '0 : rr_pick(req_valid, last);
    gnt = '0;
    if (acc) gnt[gnt_id] = 1'b1;
  end

  assign req_ready = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= IDW'(N-1);
      tag_pipe <= '0;
      sq_in    <= '0;
      res_data <= '0;
      res_id   <= '0;
      res_vld  <= 1'b0;
    end else begin
      tag_pipe[0] <= '{valid: acc, id: TAG_IDW'(gnt_id)};
      for (int s = 1; s <= SQRT_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      // sq_in only moves on accept so the sqrt input stays quiet in bubbles.
      if (acc) begin
        sq_in <= req_data[SQRT_IN_W*gnt_id +: SQRT_IN_W];
        last  <= gnt_id;
      end
      res_data <= sq_out;
      res_id   <= tag_pipe[SQRT_LAT].id[IDW-1:0];
      res_vld  <= tag_pipe[SQRT_LAT].valid;
    end
  end

  sqrt #(.LAT(SQRT_LAT)) u_sqrt (
    .clk (clk),
    .in  (sq_in),
    .out (sq_out)
  );

  always_comb begin
    res_valid = '0;
    if (res_vld) res_valid[res_id] = 1'b1;
  end

  always_comb begin
    idle = 1'b1;
    for (int s = 0; s <= SQRT_LAT; s++)
      if (tag_pipe[s].valid) idle = 1'b0;
  end

endmodule
